// File: rtl/tank_pkg.sv
// tank_pkg: shared constants and width helper for the tank level indicator
package tank_pkg;
  localparam int WIDTH_DEF    = 8;
  localparam int DEBOUNCE_DEF = 2;
  function automatic int LVL_W(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/tank_debounce.sv
// tank_debounce: accepts a sensor pattern once it has been seen on DEBOUNCE consecutive edges
module tank_debounce #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] water_i,
  output logic [WIDTH-1:0] acc_d_o,
  output logic             upd_o
);
  localparam int SW = $clog2(DEBOUNCE + 1);
  logic [WIDTH-1:0] cand_q, acc_q;
  logic [SW-1:0]    stab_q, stab_d;
  // restart the count on any change, otherwise saturate at DEBOUNCE
  always_comb begin
    stab_d = (water_i != cand_q) ? SW'(1) : (stab_q == SW'(DEBOUNCE)) ? stab_q : stab_q + 1'b1;
  end
  assign upd_o   = stab_d == SW'(DEBOUNCE);
  assign acc_d_o = upd_o ? water_i : acc_q;
  // candidate, stability count and accepted pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
      stab_q <= '0;
      acc_q  <= '0;
    end else begin
      cand_q <= water_i;
      stab_q <= stab_d;
      acc_q  <= acc_d_o;
    end
  end
endmodule

// File: rtl/tank_level_indicator.sv
// tank_level_indicator: debounced tank level with empty/half/full flags and sensor fault
module tank_level_indicator
  import tank_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         water,
  output logic                     full,
  output logic                     empty,
  output logic                     half,
  output logic [LVL_W(WIDTH)-1:0]  level,
  output logic                     fault
);
  localparam int LW = LVL_W(WIDTH);
  if (WIDTH < 2 || WIDTH % 2 != 0 || DEBOUNCE < 1) begin : g_param_err
    $error("tank_level_indicator: WIDTH must be even and >= 2, DEBOUNCE >= 1");
  end
  logic             upd;
  logic [WIDTH-1:0] acc_d;
  logic [LW-1:0]    level_d, level_q;
  logic             full_d, empty_d, half_d, fault_d;
  logic             full_q, empty_q, half_q, fault_q;
  tank_debounce #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .water_i(water),
    .acc_d_o(acc_d),
    .upd_o  (upd)
  );
  // popcount and thermometer check of the pattern being loaded into acc
  always_comb begin
    level_d = '0;
    fault_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) level_d = level_d + LW'(acc_d[i]);
    for (int i = 1; i < WIDTH; i++) fault_d = fault_d | (acc_d[i] & ~acc_d[i-1]);
    full_d  = level_d == LW'(WIDTH);
    empty_d = level_d == '0;
    half_d  = (level_d >= LW'(WIDTH / 2)) && !full_d;
  end
  // output registers follow acc, updating only when a pattern is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      half_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (upd) begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      half_q  <= half_d;
      fault_q <= fault_d;
    end
  end
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign half  = half_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_tank_level_indicator.sv
// tb_tank_level_indicator: directed and random checks of the debounced tank monitor
module tb_tank_level_indicator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] water = 8'h00;
  logic       full, empty, half, fault;
  logic [3:0] level;
  logic [7:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tank_level_indicator #(.WIDTH(8), .DEBOUNCE(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .water(water),
    .full (full),
    .empty(empty),
    .half (half),
    .level(level),
    .fault(fault)
  );

  // observed outputs packed as {level, full, empty, half, fault}
  assign obs = {level, full, empty, half, fault};

  function automatic logic [7:0] model(input logic [7:0] w);
    logic [3:0] l;
    logic       thermo;
    l      = 4'($countones(w));
    thermo = ((9'(w) & (9'(w) + 9'd1)) == 9'd0);
    return {l, l == 4'd8, l == 4'd0, (l >= 4'd4) && (l != 4'd8), !thermo};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    water = 8'h00;
    #12;
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL reset: got %h expected %h", obs, {4'd0, 4'b0100}); end
    rst_n = 1'b1;
    step(2);
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs, {4'd0, 4'b0100}); end
  endtask

  task automatic test_full;
    water = 8'hFF;
    step(1);
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL full_first_edge: got %h expected %h", obs, {4'd0, 4'b0100}); end
    step(1);
    checks++; if (obs !== {4'd8, 4'b1000}) begin errors++; $display("FAIL full: got %h expected %h", obs, {4'd8, 4'b1000}); end
  endtask

  task automatic test_half;
    water = 8'h0F;
    step(2);
    checks++; if (obs !== {4'd4, 4'b0010}) begin errors++; $display("FAIL half_0f: got %h expected %h", obs, {4'd4, 4'b0010}); end
    water = 8'h07;
    step(1);
    checks++; if (obs !== {4'd4, 4'b0010}) begin errors++; $display("FAIL half_07_hold: got %h expected %h", obs, {4'd4, 4'b0010}); end
    step(1);
    checks++; if (obs !== {4'd3, 4'b0000}) begin errors++; $display("FAIL half_07: got %h expected %h", obs, {4'd3, 4'b0000}); end
    water = 8'h7F;
    step(2);
    checks++; if (obs !== {4'd7, 4'b0010}) begin errors++; $display("FAIL half_7f: got %h expected %h", obs, {4'd7, 4'b0010}); end
  endtask

  task automatic test_fault;
    water = 8'b1000_0001;
    step(2);
    checks++; if (obs !== {4'd2, 4'b0001}) begin errors++; $display("FAIL fault_81: got %h expected %h", obs, {4'd2, 4'b0001}); end
    water = 8'b0001_0001;
    step(2);
    checks++; if (obs !== {4'd2, 4'b0001}) begin errors++; $display("FAIL fault_11: got %h expected %h", obs, {4'd2, 4'b0001}); end
    water = 8'h00;
    step(2);
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL fault_clear: got %h expected %h", obs, {4'd0, 4'b0100}); end
  endtask

  task automatic test_debounce;
    water = 8'h00;
    step(2);
    water = 8'hFF;
    step(1);
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL glitch_on: got %h expected %h", obs, {4'd0, 4'b0100}); end
    water = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step(1);
      checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL glitch_after%0d: got %h expected %h", c, obs, {4'd0, 4'b0100}); end
    end
    water = 8'hFF;
    step(1);
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL hold_first: got %h expected %h", obs, {4'd0, 4'b0100}); end
    step(1);
    checks++; if (obs !== {4'd8, 4'b1000}) begin errors++; $display("FAIL hold_second: got %h expected %h", obs, {4'd8, 4'b1000}); end
  endtask

  task automatic test_back_to_back;
    water = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step(1);
      checks++; if (obs !== {4'd8, 4'b1000}) begin errors++; $display("FAIL reapply%0d: got %h expected %h", c, obs, {4'd8, 4'b1000}); end
    end
  endtask

  task automatic test_async_reset;
    water = 8'hFF;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL async_reset: got %h expected %h", obs, {4'd0, 4'b0100}); end
    #2;
    rst_n = 1'b1;
    step(1);
    checks++; if (obs !== {4'd0, 4'b0100}) begin errors++; $display("FAIL post_reset_first: got %h expected %h", obs, {4'd0, 4'b0100}); end
    step(1);
    checks++; if (obs !== {4'd8, 4'b1000}) begin errors++; $display("FAIL post_reset_full: got %h expected %h", obs, {4'd8, 4'b1000}); end
  endtask

  task automatic test_random;
    logic [7:0] v, e, prev;
    int h;
    prev = model(water);
    for (int i = 0; i < 14; i++) begin
      v = 8'($urandom_range(0, 255));
      h = $urandom_range(2, 4);
      water = v;
      for (int c = 0; c < h; c++) begin
        step(1);
        e = (c == 0) ? prev : model(v);
        checks++; if (obs !== e) begin errors++; $display("FAIL random%0d_c%0d water=%h: got %h expected %h", i, c, v, obs, e); end
      end
      prev = model(v);
    end
  endtask

  initial begin
    test_reset;
    test_full;
    test_half;
    test_fault;
    test_debounce;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
